f3_puzzle_engine: RTL and testbench
===================================

# f3_puzzle_engine

Sliding-puzzle board engine for function 3: consumes the `write`/`instruction`/`scramble` outputs of the function-3 key processor and maintains a 4x4 fifteen-puzzle board. It turns each new key press into exactly one blank-tile move. It runs a pseudo-random scramble sequence on request. It exposes a registered tile read port, plus status, to the VGA tile renderer downstream.

## Interface
- `SCRAMBLE_MOVES`, 64: random move attempts per scramble (1..255).
- `LFSR_SEED`, 16'hACE1: LFSR value after reset (non-zero).
- `COUNT_W`, 10: move counter width.

- `sysclk` in 1: system clock. One clock only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `write` in 1: level, high while a direction key is held.
- `instruction` in 4: 0 none, 1 North, 2 East, 3 West, 4 South; other values ignored.
- `scramble` in 1: level, high while the scramble key is held.
- `rd_addr` in 4: tile index, row-major, 0 = top-left.
- `rd_data` out 4: tile value at `rd_addr`; 0 = blank.
- `blank_pos` out 4: current index of the blank.
- `move_count` out COUNT_W: legal user moves since the last scramble or reset; saturating.
- `solved` out 1: board equals the solved pattern.
- `busy` out 1: engine in MOVE or SCRAMBLE; new requests are dropped.

## Operation
- Board storage: 16 x 4-bit registers.
- Solved pattern: tile i = i+1 for i = 0..14; tile 15 = 0.
- Position decode: row = pos[3:2], col = pos[1:0].
- Target position per direction (the blank moves in the named direction):
  - North: pos-4, legal if row≠0.
  - South: pos+4, legal if row≠3.
  - East: pos+1, legal if col≠3.
  - West: pos-1, legal if col≠0.
- Move = swap board[blank_pos] with board[target], then blank_pos ← target.
- Edge detect: `write_d` and `scramble_d` registers.
  - Move request: `write & ~write_d` with instruction 1..4.
  - Scramble request: `scramble & ~scramble_d`.
  - A held key yields one request only.
- States:
  - IDLE, on scramble request → SCRAMBLE: load `SCRAMBLE_MOVES` into the iteration counter; clear `move_count`.
  - IDLE, else on move request → MOVE: latch direction.
  - IDLE, else: stay.
  - MOVE: if legal, perform swap and increment `move_count` (saturating at all-ones); illegal moves change nothing. → IDLE.
  - SCRAMBLE: one attempt per cycle. Direction = lfsr[1:0] (0 N, 1 E, 2 W, 3 S). Swap if legal; an illegal attempt still consumes an iteration. Decrement the counter; at 1 → IDLE. `move_count` is untouched.
- Requests seen while `busy`: dropped, not queued.
- Edge registers update every cycle regardless of state.
- Scramble and move requests in the same cycle: scramble wins; the move is dropped.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in all states, so user timing seeds the randomness.
- `solved`: registered compare of the full board every cycle.

## Timing
- Reset values:
  - board = solved pattern; `blank_pos` = 15; `move_count` = 0.
  - `solved` = 1; `busy` = 0; `rd_data` = 0.
  - state IDLE; lfsr = `LFSR_SEED`; `write_d` = `scramble_d` = 0.
- Move request sampled at edge k → `busy` high after k. Swap, `blank_pos` and `move_count` are visible after k+1; `busy` is low after k+1. `solved` is valid after k+2.
- Scramble request at edge k → `move_count` = 0 after k. Attempts occur at edges k+1..k+SCRAMBLE_MOVES. `busy` is high from after k until after k+SCRAMBLE_MOVES.
- `rd_data`: 1-cycle latency. The value after edge k = board[`rd_addr`] as held before edge k.
- Reset asserted mid-MOVE or mid-SCRAMBLE: immediate return to all reset values; the board is never left half-swapped.

## Structure
- Package `f3_pkg`:
  - direction codes: DIR_NONE=0, DIR_N=1, DIR_E=2, DIR_W=3, DIR_S=4, DIR_SCRAMBLE=5 (shared with the key processor);
  - state enum IDLE/MOVE/SCRAMBLE;
  - BOARD_DIM=4; BLANK=4'd0.
- Sub-module `f3_lfsr16`: free-running LFSR with parameterised seed; outputs the 16-bit state.
- Neighbour/legality decode is a local function inside the engine.

## Test plan
- Reset: release `rst_n` → `rd_data` sweep over addr 0..15 returns 1..15, 0; `blank_pos`=15; `solved`=1; `move_count`=0; `busy`=0.
- Legal move: instruction=1 with one `write` rising edge.
  - Expected: `blank_pos`=11, tile 15 = 12, tile 11 = 0, `move_count`=1, `solved`=0 two cycles later.
  - Then South → `blank_pos`=15, `move_count`=2, `solved`=1.
- Illegal move and key hold:
  - East at `blank_pos`=15 → board and `move_count` unchanged.
  - `write` held high 100 cycles with North → exactly one move.
- Scramble: `scramble` pulse → `busy` high exactly 64 cycles and `move_count`=0. Afterwards the 16 tiles are a permutation of 0..15 and `blank_pos` indexes the 0 tile.
- Contention: `write` edge during scramble `busy` → dropped. Scramble and move edges in the same cycle → scramble only, `move_count`=0.
- Reset mid-scramble: assert `rst_n`=0 at iteration 20 → solved pattern and all reset values immediately; no further activity after release.

Source files
------------

// File: rtl/f3_puzzle_engine_pkg.sv
// Shared definitions for the function-3 sliding puzzle: direction codes,
// engine states and board geometry.
package f3_pkg;

   localparam logic [3:0] DIR_NONE     = 4'd0;
   localparam logic [3:0] DIR_N        = 4'd1;
   localparam logic [3:0] DIR_E        = 4'd2;
   localparam logic [3:0] DIR_W        = 4'd3;
   localparam logic [3:0] DIR_S        = 4'd4;
   localparam logic [3:0] DIR_SCRAMBLE = 4'd5;

   localparam int BOARD_DIM = 4;
   localparam int TILES     = BOARD_DIM * BOARD_DIM;
   localparam logic [3:0] BLANK = 4'd0;

   typedef enum logic [1:0] {IDLE, MOVE, SCRAMBLE} state_t;

   // Tile value of the solved pattern at a given index.
   function automatic logic [3:0] solved_tile(input int unsigned idx);
      return (idx == TILES - 1) ? BLANK : 4'(idx + 1);
   endfunction

endpackage

// File: rtl/f3_puzzle_engine_if.sv
// Key-processor inputs and renderer-facing outputs of the puzzle engine.
interface f3_puzzle_engine_if #(
   parameter int COUNT_W = 10
) ();
   logic               write;
   logic [3:0]         instruction;
   logic               scramble;
   logic [3:0]         rd_addr;
   logic [3:0]         rd_data;
   logic [3:0]         blank_pos;
   logic [COUNT_W-1:0] move_count;
   logic               solved;
   logic               busy;

   modport master (
      output write, instruction, scramble, rd_addr,
      input  rd_data, blank_pos, move_count, solved, busy
   );

   modport slave (
      input  write, instruction, scramble, rd_addr,
      output rd_data, blank_pos, move_count, solved, busy
   );
endinterface

// File: rtl/f3_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module f3_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SEED;
      else        state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
   end

endmodule

// File: rtl/f3_puzzle_engine.sv
// 4x4 fifteen-puzzle engine: one blank move per key press, LFSR scramble,
// registered tile read port and status for the tile renderer.
module f3_puzzle_engine #(
   parameter int          SCRAMBLE_MOVES = 64,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter int          COUNT_W        = 10
) (
   input  logic               sysclk,
   input  logic               rst_n,
   f3_puzzle_engine_if.slave  bus
);
   import f3_pkg::*;

   state_t             state, state_nxt;
   logic               write_d, scramble_d;
   logic [3:0]         board [TILES];
   logic [3:0]         blank_pos, dir_q, step_dir, target;
   logic [7:0]         iter;
   logic [COUNT_W-1:0] move_count;
   logic               solved_q, board_is_solved;
   logic [3:0]         rd_q;
   logic [15:0]        lfsr;
   logic               move_req, scr_req;
   logic               latch_dir, load_iter, try_move, count_move, do_swap;
   logic [4:0]         nb;
   logic               unused_lfsr;

   // Returns {legal, target index} for moving the blank from pos in dir.
   function automatic logic [4:0] neighbour(input logic [3:0] pos, input logic [3:0] dir);
      logic [1:0] row;
      logic [1:0] col;
      row = pos[3:2];
      col = pos[1:0];
      case (dir)
         DIR_N:   return {row != 2'd0, pos - 4'd4};
         DIR_S:   return {row != 2'd3, pos + 4'd4};
         DIR_E:   return {col != 2'd3, pos + 4'd1};
         DIR_W:   return {col != 2'd0, pos - 4'd1};
         default: return {1'b0, pos};
      endcase
   endfunction

   f3_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (sysclk),
      .rst_n (rst_n),
      .state (lfsr)
   );
   assign unused_lfsr = ^lfsr[15:2];

   assign move_req = bus.write & ~write_d &
                     (bus.instruction >= DIR_N) & (bus.instruction <= DIR_S);
   assign scr_req  = bus.scramble & ~scramble_d;

   always_comb begin
      state_nxt  = state;
      latch_dir  = 1'b0;
      load_iter  = 1'b0;
      try_move   = 1'b0;
      count_move = 1'b0;
      step_dir   = DIR_NONE;
      case (state)
         IDLE: begin
            if (scr_req) begin
               state_nxt = SCRAMBLE;
               load_iter = 1'b1;
            end else if (move_req) begin
               state_nxt = MOVE;
               latch_dir = 1'b1;
            end
         end
         MOVE: begin
            try_move   = 1'b1;
            count_move = 1'b1;
            step_dir   = dir_q;
            state_nxt  = IDLE;
         end
         SCRAMBLE: begin
            // lfsr[1:0] = 0..3 maps onto N,E,W,S which are codes 1..4
            try_move = 1'b1;
            step_dir = {2'b00, lfsr[1:0]} + 4'd1;
            if (iter == 8'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign nb      = neighbour(blank_pos, step_dir);
   assign do_swap = try_move & nb[4];
   assign target  = nb[3:0];

   always_comb begin
      board_is_solved = 1'b1;
      for (int unsigned i = 0; i < TILES; i++)
         if (board[i] != solved_tile(i)) board_is_solved = 1'b0;
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < TILES; i++) board[i] <= solved_tile(i);
         blank_pos  <= 4'd15;
         move_count <= '0;
         write_d    <= 1'b0;
         scramble_d <= 1'b0;
         dir_q      <= DIR_NONE;
         iter       <= '0;
         solved_q   <= 1'b1;
         rd_q       <= '0;
      end else begin
         write_d    <= bus.write;
         scramble_d <= bus.scramble;
         solved_q   <= board_is_solved;
         rd_q       <= board[bus.rd_addr];
         if (latch_dir) dir_q <= bus.instruction;
         if (load_iter) begin
            iter       <= 8'(SCRAMBLE_MOVES);
            move_count <= '0;
         end else if (state == SCRAMBLE) begin
            iter <= iter - 8'd1;
         end
         if (do_swap) begin
            board[blank_pos] <= board[target];
            board[target]    <= BLANK;
            blank_pos        <= target;
            if (count_move && move_count != '1) move_count <= move_count + 1'b1;
         end
      end
   end

   assign bus.rd_data    = rd_q;
   assign bus.blank_pos  = blank_pos;
   assign bus.move_count = move_count;
   assign bus.solved     = solved_q;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_f3_puzzle_engine.sv
// Self-checking bench for f3_puzzle_engine: table-driven moves, read-port
// scoreboard against a local board model, scramble and reset corner cases.
module tb_f3_puzzle_engine;
   import f3_pkg::*;

   typedef struct {
      logic [3:0] instr;
      logic       exp_busy;
      logic [3:0] exp_blank;
      int         exp_count;
      logic       exp_solved;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   f3_puzzle_engine_if #(.COUNT_W(10)) bus ();

   f3_puzzle_engine #(
      .SCRAMBLE_MOVES (64),
      .LFSR_SEED      (16'hACE1),
      .COUNT_W        (10)
   ) dut (
      .sysclk (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int         checks   = 0;
   int         failures = 0;
   logic [3:0] model [16];
   logic [3:0] seen  [16];
   logic [3:0] exp_q [$];
   vec_t       vecs  [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 15; i++) model[i] = 4'(i + 1);
      model[15] = 4'd0;
   endtask

   task automatic model_move(input logic [3:0] dir);
      int b, r, c, t;
      b = 0;
      for (int i = 0; i < 16; i++) if (model[i] == 4'd0) b = i;
      r = b / 4;
      c = b % 4;
      t = -1;
      if (dir == 4'd1 && r > 0) t = b - 4;
      if (dir == 4'd4 && r < 3) t = b + 4;
      if (dir == 4'd2 && c < 3) t = b + 1;
      if (dir == 4'd3 && c > 0) t = b - 1;
      if (t >= 0) begin
         model[b] = model[t];
         model[t] = 4'd0;
      end
   endtask

   // Reads every tile; expected tiles are queued when the address is driven
   // and popped when the registered read data appears one cycle later.
   task automatic sweep(input string tag, input bit use_model);
      logic [3:0] e;
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i > 0) begin
            seen[i-1] = bus.rd_data;
            if (use_model) begin
               e = exp_q.pop_front();
               check($sformatf("%s_tile%0d", tag, i - 1), bus.rd_data, e);
            end
         end
         if (i < 16) begin
            bus.rd_addr = 4'(i);
            if (use_model) exp_q.push_back(model[i]);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.write = 1'b0;
      bus.scramble = 1'b0;
      bus.instruction = 4'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic press(input logic [3:0] dir);
      @(negedge clk);
      bus.instruction = dir;
      bus.write = 1'b1;
      @(negedge clk);
      bus.write = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic count_busy(input string tag, input int midway_write);
      int n;
      n = 0;
      while (bus.busy && n < 300) begin
         n++;
         if (midway_write != 0 && n == 10) begin
            bus.instruction = DIR_N;
            bus.write = 1'b1;
         end
         if (n == 12) bus.write = 1'b0;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, n, 64);
   endtask

   function automatic vec_t mk(input logic [3:0] i, input logic b, input logic [3:0] bp,
                               input int c, input logic s);
      vec_t v;
      v.instr = i; v.exp_busy = b; v.exp_blank = bp; v.exp_count = c; v.exp_solved = s;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] mask;
      logic        is_solved;

      vecs[0]  = mk(DIR_N, 1, 11, 1, 0);
      vecs[1]  = mk(DIR_S, 1, 15, 2, 1);
      vecs[2]  = mk(DIR_E, 1, 15, 2, 1);
      vecs[3]  = mk(DIR_S, 1, 15, 2, 1);
      vecs[4]  = mk(DIR_W, 1, 14, 3, 0);
      vecs[5]  = mk(DIR_W, 1, 13, 4, 0);
      vecs[6]  = mk(DIR_N, 1,  9, 5, 0);
      vecs[7]  = mk(DIR_E, 1, 10, 6, 0);
      vecs[8]  = mk(DIR_NONE, 0, 10, 6, 0);
      vecs[9]  = mk(4'd7, 0, 10, 6, 0);
      vecs[10] = mk(DIR_S, 1, 14, 7, 0);
      vecs[11] = mk(DIR_E, 1, 15, 8, 0);
      vecs[12] = mk(DIR_W, 1, 14, 9, 0);
      vecs[13] = mk(DIR_N, 1, 10, 10, 0);
      vecs[14] = mk(DIR_W, 1,  9, 11, 0);
      vecs[15] = mk(DIR_S, 1, 13, 12, 0);
      vecs[16] = mk(DIR_E, 1, 14, 13, 0);
      vecs[17] = mk(DIR_E, 1, 15, 14, 1);

      rst_n = 1'b0;
      bus.write = 1'b0;
      bus.scramble = 1'b0;
      bus.instruction = 4'd0;
      bus.rd_addr = 4'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      check("rst_blank", bus.blank_pos, 15);
      check("rst_solved", bus.solved, 1);
      check("rst_count", bus.move_count, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rd_data", bus.rd_data, 0);
      sweep("rst", 1);

      foreach (vecs[k]) begin
         @(negedge clk);
         bus.instruction = vecs[k].instr;
         bus.write = 1'b1;
         @(negedge clk);
         bus.write = 1'b0;
         check($sformatf("v%0d_busy", k), bus.busy, vecs[k].exp_busy);
         @(negedge clk);
         check($sformatf("v%0d_blank", k), bus.blank_pos, vecs[k].exp_blank);
         check($sformatf("v%0d_count", k), bus.move_count, vecs[k].exp_count);
         check($sformatf("v%0d_idle", k), bus.busy, 0);
         @(negedge clk);
         check($sformatf("v%0d_solved", k), bus.solved, vecs[k].exp_solved);
         model_move(vecs[k].instr);
         sweep($sformatf("v%0d", k), 1);
      end

      // Key held for 100 cycles must move exactly once.
      @(negedge clk);
      bus.instruction = DIR_N;
      bus.write = 1'b1;
      repeat (100) @(negedge clk);
      bus.write = 1'b0;
      repeat (3) @(negedge clk);
      check("hold_blank", bus.blank_pos, 11);
      check("hold_count", bus.move_count, 15);
      model_move(DIR_N);
      sweep("hold", 1);
      press(DIR_S);
      check("hold_back_blank", bus.blank_pos, 15);
      check("hold_back_solved", bus.solved, 1);

      // Scramble with a write edge arriving while busy.
      @(negedge clk);
      bus.scramble = 1'b1;
      @(negedge clk);
      bus.scramble = 1'b0;
      check("scr_busy_start", bus.busy, 1);
      check("scr_count_clear", bus.move_count, 0);
      count_busy("scr", 1);
      repeat (3) @(negedge clk);
      check("scr_count_after", bus.move_count, 0);
      check("scr_idle_after", bus.busy, 0);
      sweep("scr", 0);
      mask = '0;
      is_solved = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mask[seen[i]] = 1'b1;
         if (seen[i] != ((i == 15) ? 4'd0 : 4'(i + 1))) is_solved = 1'b0;
      end
      check("scr_permutation", mask, 16'hFFFF);
      check("scr_blank_tile", seen[bus.blank_pos], 0);
      check("scr_solved_flag", bus.solved, is_solved);

      // Scramble and move edges in the same cycle: scramble only.
      do_reset();
      press(DIR_N);
      check("same_pre_count", bus.move_count, 1);
      @(negedge clk);
      bus.scramble = 1'b1;
      bus.instruction = DIR_S;
      bus.write = 1'b1;
      @(negedge clk);
      bus.scramble = 1'b0;
      bus.write = 1'b0;
      check("same_busy", bus.busy, 1);
      check("same_count", bus.move_count, 0);
      count_busy("same", 0);
      repeat (3) @(negedge clk);
      check("same_count_after", bus.move_count, 0);

      // Reset asserted part-way through a scramble.
      do_reset();
      @(negedge clk);
      bus.scramble = 1'b1;
      @(negedge clk);
      bus.scramble = 1'b0;
      repeat (19) @(negedge clk);
      check("midrst_busy_before", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_blank", bus.blank_pos, 15);
      check("midrst_count", bus.move_count, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_solved", bus.solved, 1);
      check("midrst_rd_data", bus.rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      sweep("midrst", 1);
      repeat (100) @(negedge clk);
      check("midrst_quiet_blank", bus.blank_pos, 15);
      check("midrst_quiet_busy", bus.busy, 0);
      check("midrst_quiet_solved", bus.solved, 1);
      sweep("midrst_quiet", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
